// File: rtl/wb_commit_unit.sv
// Writeback commit unit: takes completed instructions from MEM, drives the
// single-port GPR/CSR write bus toward decode, splits dual GPR+CSR writers
// over two cycles, counts retirements, checks program order and halts on a
// write to the halt CSR.
//
// Handshake: an instruction transfers on a cycle where in_valid && in_ready.
// in_ready is 1 only while in ACCEPT and not in reset. The producer holds its
// inputs while in_ready is 0, and the unit ignores in_valid on those cycles.
module wb_commit_unit #(
    parameter int                   DBITS     = 32,
    parameter int                   REGNOBITS = 5,
    parameter int                   CSRNOBITS = 4,
    parameter logic [CSRNOBITS-1:0] HALT_CSR  = 4'hF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_wr_reg,
    input  logic [REGNOBITS-1:0] in_wregno,
    input  logic [DBITS-1:0]     in_regval,
    input  logic                 in_wr_csr,
    input  logic [CSRNOBITS-1:0] in_wcsrno,
    input  logic [DBITS-1:0]     in_csrval,
    input  logic [DBITS-1:0]     in_inst_count,
    output logic                 wr_reg_WB,
    output logic [REGNOBITS-1:0] wregno_WB,
    output logic                 wr_csr_WB,
    output logic [CSRNOBITS-1:0] wcsrno_WB,
    output logic [DBITS-1:0]     regval_WB,
    output logic [DBITS-1:0]     retired_count,
    output logic                 order_error,
    output logic                 halt,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_ACCEPT   = 2'd0,
        S_CSR_PEND = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   wr_reg_q, wr_reg_d;
    logic [REGNOBITS-1:0]   wregno_q, wregno_d;
    logic                   wr_csr_q, wr_csr_d;
    logic [CSRNOBITS-1:0]   wcsrno_q, wcsrno_d;
    logic [DBITS-1:0]       regval_q, regval_d;
    logic [CSRNOBITS-1:0]   pend_csrno_q, pend_csrno_d;
    logic [DBITS-1:0]       pend_csrval_q, pend_csrval_d;
    logic [DBITS-1:0]       retired_q, retired_d;
    logic [DBITS-1:0]       expected_q, expected_d;
    logic                   first_done_q, first_done_d;
    logic                   order_error_q, order_error_d;
    logic                   halt_q, halt_d;

    logic                   accept;
    logic                   eff_reg;

    assign in_ready = (state_q == S_ACCEPT) && !reset;
    assign accept   = in_valid && in_ready;
    // x0 writes are dropped but the instruction still retires.
    assign eff_reg  = in_wr_reg && (in_wregno != '0);

    // Next-state, write-bus and bookkeeping logic; strobes default to idle zeros.
    always_comb begin
        state_d       = state_q;
        wr_reg_d      = 1'b0;
        wregno_d      = '0;
        wr_csr_d      = 1'b0;
        wcsrno_d      = '0;
        regval_d      = '0;
        pend_csrno_d  = pend_csrno_q;
        pend_csrval_d = pend_csrval_q;
        retired_d     = retired_q;
        expected_d    = expected_q;
        first_done_d  = first_done_q;
        order_error_d = order_error_q;
        // halt lags entry into HALTED by one cycle so it rises after the strobe.
        halt_d        = (state_q == S_HALTED);

        case (state_q)
            S_ACCEPT: begin
                if (accept) begin
                    if (eff_reg) begin
                        wr_reg_d = 1'b1;
                        wregno_d = in_wregno;
                        regval_d = in_regval;
                        if (in_wr_csr) begin
                            // CSR half goes out next cycle on the shared port.
                            pend_csrno_d  = in_wcsrno;
                            pend_csrval_d = in_csrval;
                            state_d       = S_CSR_PEND;
                        end
                    end else if (in_wr_csr) begin
                        wr_csr_d = 1'b1;
                        wcsrno_d = in_wcsrno;
                        regval_d = in_csrval;
                        if (in_wcsrno == HALT_CSR) begin
                            state_d = S_HALTED;
                        end
                    end
                end
            end
            S_CSR_PEND: begin
                wr_csr_d = 1'b1;
                wcsrno_d = pend_csrno_q;
                regval_d = pend_csrval_q;
                state_d  = (pend_csrno_q == HALT_CSR) ? S_HALTED : S_ACCEPT;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_ACCEPT;
            end
        endcase

        if (accept) begin
            retired_d = retired_q + 1'b1;
            if (first_done_q && (in_inst_count != expected_q)) begin
                order_error_d = 1'b1;
            end
            expected_d   = in_inst_count + 1'b1;
            first_done_d = 1'b1;
        end
    end

    // State and registered outputs; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_ACCEPT;
            wr_reg_q      <= 1'b0;
            wregno_q      <= '0;
            wr_csr_q      <= 1'b0;
            wcsrno_q      <= '0;
            regval_q      <= '0;
            pend_csrno_q  <= '0;
            pend_csrval_q <= '0;
            retired_q     <= '0;
            expected_q    <= '0;
            first_done_q  <= 1'b0;
            order_error_q <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_reg_q      <= wr_reg_d;
            wregno_q      <= wregno_d;
            wr_csr_q      <= wr_csr_d;
            wcsrno_q      <= wcsrno_d;
            regval_q      <= regval_d;
            pend_csrno_q  <= pend_csrno_d;
            pend_csrval_q <= pend_csrval_d;
            retired_q     <= retired_d;
            expected_q    <= expected_d;
            first_done_q  <= first_done_d;
            order_error_q <= order_error_d;
            halt_q        <= halt_d;
        end
    end

    assign wr_reg_WB     = wr_reg_q;
    assign wregno_WB     = wregno_q;
    assign wr_csr_WB     = wr_csr_q;
    assign wcsrno_WB     = wcsrno_q;
    assign regval_WB     = regval_q;
    assign retired_count = retired_q;
    assign order_error   = order_error_q;
    assign halt          = halt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed instruction vectors, a transaction-level
// model scheduling expected write-bus events by cycle, a per-cycle compare
// process and literal pin checks at the points the test plan names.
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_wr_reg;
    logic [4:0]  in_wregno;
    logic [31:0] in_regval;
    logic        in_wr_csr;
    logic [3:0]  in_wcsrno;
    logic [31:0] in_csrval;
    logic [31:0] in_inst_count;
    logic        wr_reg_WB;
    logic [4:0]  wregno_WB;
    logic        wr_csr_WB;
    logic [3:0]  wcsrno_WB;
    logic [31:0] regval_WB;
    logic [31:0] retired_count;
    logic        order_error;
    logic        halt;
    logic [1:0]  state_dbg;

    wb_commit_unit #(
        .DBITS(32), .REGNOBITS(5), .CSRNOBITS(4), .HALT_CSR(4'hF)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wr_reg(in_wr_reg), .in_wregno(in_wregno), .in_regval(in_regval),
        .in_wr_csr(in_wr_csr), .in_wcsrno(in_wcsrno), .in_csrval(in_csrval),
        .in_inst_count(in_inst_count),
        .wr_reg_WB(wr_reg_WB), .wregno_WB(wregno_WB),
        .wr_csr_WB(wr_csr_WB), .wcsrno_WB(wcsrno_WB), .regval_WB(regval_WB),
        .retired_count(retired_count), .order_error(order_error), .halt(halt),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit checking = 1'b0;

    // ---------------- model ----------------
    typedef struct {
        int          cyc;
        logic        is_csr;
        logic [4:0]  idx;
        logic [31:0] val;
    } wb_ev_t;

    wb_ev_t      exp_q[$];
    logic [31:0] m_retired;
    logic [31:0] m_expected;
    bit          m_first_done;
    bit          m_order;
    int          m_busy_until;
    int          m_stop_cyc;
    int          m_halt_cyc;
    int          m_dc_cyc;

    localparam int NEVER = 1 << 30;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_ready(input int c);
        return !reset && (c >= m_busy_until) && (c < m_stop_cyc);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_retired    = 0;
        m_expected   = 0;
        m_first_done = 0;
        m_order      = 0;
        m_busy_until = 0;
        m_stop_cyc   = NEVER;
        m_halt_cyc   = NEVER;
        m_dc_cyc     = -1;
    endtask

    // Accept at the edge ending cycle cyc: effects appear from cycle cyc+1.
    task automatic model_accept(input logic wr_reg, input logic [4:0] regno,
                                input logic [31:0] regval, input logic wr_csr,
                                input logic [3:0] csrno, input logic [31:0] csrval,
                                input logic [31:0] cnt);
        int  k   = cyc;
        bit  eff = wr_reg && (regno != 0);
        int  t;
        m_retired = m_retired + 1;
        if (m_first_done && (cnt != m_expected)) m_order = 1;
        m_expected   = cnt + 1;
        m_first_done = 1;
        if (eff) exp_q.push_back('{k + 1, 1'b0, regno, regval});
        if (wr_csr) begin
            t = eff ? k + 2 : k + 1;
            exp_q.push_back('{t, 1'b1, {1'b0, csrno}, csrval});
            if (eff) m_busy_until = k + 2;
            if (csrno == 4'hF) begin
                m_stop_cyc = t;
                m_halt_cyc = t + 1;
                if (!eff) m_dc_cyc = k + 1;
            end
        end
    endtask

    // ---------------- compare process ----------------
    initial forever begin
        wb_ev_t e;
        bit     have;
        @(posedge clk);
        cyc++;
        #2;
        if (checking) begin
            have = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            if (have) e = exp_q.pop_front();
            chk("wr_reg_WB", wr_reg_WB, have && !e.is_csr);
            chk("wregno_WB", wregno_WB, (have && !e.is_csr) ? e.idx : 5'd0);
            chk("wr_csr_WB", wr_csr_WB, have && e.is_csr);
            chk("wcsrno_WB", wcsrno_WB, (have && e.is_csr) ? e.idx[3:0] : 4'd0);
            chk("regval_WB", regval_WB, have ? e.val : 32'd0);
            chk("one_strobe", wr_reg_WB && wr_csr_WB, 0);
            chk("retired_count", retired_count, m_retired);
            chk("order_error", order_error, m_order);
            chk("halt", halt, cyc >= m_halt_cyc);
            if (cyc != m_dc_cyc) chk("in_ready", in_ready, model_ready(cyc));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_valid = 0;
        reset    = 1;
        model_reset();
        checking = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_reg", wr_reg_WB, 0);
        chk("rst_wr_csr", wr_csr_WB, 0);
        chk("rst_retired", retired_count, 0);
        chk("rst_order", order_error, 0);
        chk("rst_halt", halt, 0);
        reset = 0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input logic wr_reg, input logic [4:0] regno,
                        input logic [31:0] regval, input logic wr_csr,
                        input logic [3:0] csrno, input logic [31:0] csrval,
                        input logic [31:0] cnt);
        int guard = 0;
        while (!model_ready(cyc) && guard < 16) begin
            in_valid = 0;
            @(negedge clk);
            guard++;
        end
        in_wr_reg     = wr_reg;
        in_wregno     = regno;
        in_regval     = regval;
        in_wr_csr     = wr_csr;
        in_wcsrno     = csrno;
        in_csrval     = csrval;
        in_inst_count = cnt;
        in_valid      = 1;
        if (model_ready(cyc)) begin
            model_accept(wr_reg, regno, regval, wr_csr, csrno, csrval, cnt);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_ready @cyc %0d: got not-ready expected ready within 16 cycles", cyc);
        end
        @(negedge clk);
    endtask

    // Present an instruction while the unit must not accept it.
    task automatic poke(input int n);
        in_wr_reg     = 1;
        in_wregno     = 5'd8;
        in_regval     = 32'hDEAD;
        in_wr_csr     = 0;
        in_inst_count = 32'd99;
        in_valid      = 1;
        for (int i = 0; i < n; i++) @(negedge clk);
        in_valid = 0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset = 1; in_valid = 0;
        in_wr_reg = 0; in_wregno = 0; in_regval = 0;
        in_wr_csr = 0; in_wcsrno = 0; in_csrval = 0; in_inst_count = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // single GPR write
        send(1, 5'd5, 32'h1234, 0, 4'd0, 0, 32'd1);
        chk("add_wr_reg", wr_reg_WB, 1);
        chk("add_wregno", wregno_WB, 5);
        chk("add_regval", regval_WB, 32'h1234);
        chk("add_retired", retired_count, 1);
        idle(1);
        chk("add_pulse_end", wr_reg_WB, 0);

        // back-to-back x1..x4
        do_reset();
        for (int i = 1; i <= 4; i++) send(1, i[4:0], 32'h100 + i, 0, 4'd0, 0, i);
        chk("b2b_retired", retired_count, 4);
        chk("b2b_wregno", wregno_WB, 4);
        chk("b2b_order", order_error, 0);

        // dual GPR + CSR
        send(1, 5'd7, 32'hA, 1, 4'd3, 32'hB, 32'd5);
        chk("dual_n1_reg", wr_reg_WB, 1);
        chk("dual_n1_csr", wr_csr_WB, 0);
        chk("dual_n1_val", regval_WB, 32'hA);
        chk("dual_n1_ready", in_ready, 0);
        idle(1);
        chk("dual_n2_reg", wr_reg_WB, 0);
        chk("dual_n2_csr", wr_csr_WB, 1);
        chk("dual_n2_csrno", wcsrno_WB, 3);
        chk("dual_n2_val", regval_WB, 32'hB);

        // x0 write dropped
        send(1, 5'd0, 32'hFF, 0, 4'd0, 0, 32'd6);
        chk("x0_no_strobe", wr_reg_WB, 0);
        chk("x0_regval", regval_WB, 0);
        chk("x0_retired", retired_count, 6);
        idle(1);

        // order error on 1,2,4 then cleared by reset
        do_reset();
        send(1, 5'd1, 32'h1, 0, 4'd0, 0, 32'd1);
        send(1, 5'd2, 32'h2, 0, 4'd0, 0, 32'd2);
        chk("ord_before", order_error, 0);
        send(1, 5'd3, 32'h3, 0, 4'd0, 0, 32'd4);
        chk("ord_flag", order_error, 1);
        send(1, 5'd4, 32'h4, 0, 4'd0, 0, 32'd5);
        idle(2);
        chk("ord_sticky", order_error, 1);
        do_reset();

        // sequence number wrap is in order
        send(0, 5'd0, 0, 0, 4'd0, 0, 32'hFFFF_FFFF);
        send(0, 5'd0, 0, 0, 4'd0, 0, 32'h0);
        chk("wrap_no_flag", order_error, 0);
        send(0, 5'd0, 0, 0, 4'd0, 0, 32'h2);
        chk("wrap_flag", order_error, 1);
        idle(1);

        // single halt CSR write
        do_reset();
        send(0, 5'd0, 0, 1, 4'hF, 32'h77, 32'd1);
        chk("halt_n1_csr", wr_csr_WB, 1);
        chk("halt_n1_csrno", wcsrno_WB, 4'hF);
        chk("halt_n1_val", regval_WB, 32'h77);
        chk("halt_n1_halt", halt, 0);
        idle(1);
        chk("halt_n2_halt", halt, 1);
        chk("halt_n2_ready", in_ready, 0);
        poke(3);
        chk("halt_ignored", retired_count, 1);
        chk("halt_no_wr", wr_reg_WB, 0);
        chk("halt_sticky", halt, 1);

        // reset while the CSR half is pending discards it
        do_reset();
        send(1, 5'd9, 32'h55, 1, 4'd2, 32'h66, 32'd1);
        chk("pend_n1_reg", wr_reg_WB, 1);
        do_reset();

        // dual write to the halt CSR: halt at N+3
        send(1, 5'd3, 32'h1, 1, 4'hF, 32'h2, 32'd1);
        chk("dhalt_n1_halt", halt, 0);
        idle(1);
        chk("dhalt_n2_csr", wr_csr_WB, 1);
        chk("dhalt_n2_halt", halt, 0);
        chk("dhalt_n2_ready", in_ready, 0);
        idle(1);
        chk("dhalt_n3_halt", halt, 1);
        idle(3);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Writeback commit unit for the 5-stage RV32 pipeline. It accepts completed instructions from the MEM stage over a valid/ready handshake. It drives the single-port register-file/CSR write bus that the decode stage consumes, and it serializes instructions that write both a GPR and a CSR, because the decode-side write port takes one write per cycle. It also keeps a retired-instruction counter, checks in-order retirement, and raises a sticky halt on a write to the halt CSR.

## Interface
Parameters:
- DBITS, 32, data width of register and CSR values
- REGNOBITS, 5, GPR index width
- CSRNOBITS, 4, CSR index width
- HALT_CSR, 4'hF, CSR index whose write halts the core

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  MEM stage presents a completed instruction
- in_ready  output  1  unit accepts the instruction this cycle
- in_wr_reg  input  1  instruction writes a GPR
- in_wregno  input  REGNOBITS  destination GPR
- in_regval  input  DBITS  GPR write value
- in_wr_csr  input  1  instruction writes a CSR
- in_wcsrno  input  CSRNOBITS  destination CSR
- in_csrval  input  DBITS  CSR write value
- in_inst_count  input  DBITS  program-order sequence number
- wr_reg_WB  output  1  GPR write strobe to decode
- wregno_WB  output  REGNOBITS  GPR index
- wr_csr_WB  output  1  CSR write strobe to decode
- wcsrno_WB  output  CSRNOBITS  CSR index
- regval_WB  output  DBITS  shared write value (GPR or CSR)
- retired_count  output  DBITS  instructions retired since reset
- order_error  output  1  sticky, out-of-order retirement detected
- halt  output  1  sticky, halt CSR written

## Operation
- Accept occurs when in_valid && in_ready. in_ready = 1 only in state ACCEPT.
- Effective GPR write: in_wr_reg && in_wregno != 0. A write to x0 is dropped silently; the instruction still retires.
- State ACCEPT. On accept, inputs are latched and the cycle after accept is driven as follows:
  - Effective GPR write only: drive a GPR write.
  - CSR write only: drive a CSR write.
  - Both: drive the GPR write, then go to CSR_PEND.
  - Neither: drive no strobes.
- State CSR_PEND: in_ready = 0; drive the latched CSR write. Then go to HALTED if the CSR is HALT_CSR, else go to ACCEPT.
- Single-CSR accept targeting HALT_CSR goes to HALTED after that write.
- State HALTED: in_ready = 0 and halt = 1 until reset.
- Invariant: wr_reg_WB and wr_csr_WB are never both 1 in the same cycle.
- regval_WB carries in_regval for a GPR write and in_csrval for a CSR write.
- Outputs are registered pulses. In any cycle with no write, wr_reg_WB, wr_csr_WB, wregno_WB, wcsrno_WB and regval_WB are all 0.
- retired_count increments by 1 on each accept and wraps from 2^DBITS-1 to 0.
- Order check:
  - The first accept after reset sets expected = in_inst_count + 1 and never flags.
  - Each later accept flags if in_inst_count != expected; order_error stays set until reset.
  - expected = in_inst_count + 1 after every accept, mod 2^DBITS.

## Timing
- Reset values: in_ready = 0 during the reset cycle, 1 in the first cycle after reset (state ACCEPT). All WB outputs = 0, retired_count = 0, order_error = 0, halt = 0. The pending CSR write and the first-accept flag are cleared.
- Latency: accept in cycle N gives the write strobe in cycle N+1.
- Dual write: GPR strobe in N+1, CSR strobe in N+2, in_ready = 0 in N+1, next accept no earlier than N+2.
- Single-write throughput: one instruction per cycle.
- retired_count and order_error update in cycle N+1.
- halt rises in the cycle after the halt CSR strobe: N+2 for a single write, N+3 for a dual write.
- Reset asserted while in CSR_PEND: the pending CSR write is discarded and no strobe follows.
- in_valid while in_ready = 0 is ignored. The MEM stage holds its inputs.

## Test plan
- ADD x5 result 0x1234, in_inst_count 1, in_valid pulsed at N -> wr_reg_WB = 1, wregno_WB = 5, regval_WB = 0x1234 at N+1 only; retired_count = 1.
- Back-to-back GPR writes to x1..x4 on 4 consecutive cycles, counts 1..4 -> 4 consecutive strobes, in_ready stays 1, retired_count = 4, order_error = 0.
- GPR x7 = 0xA and CSR 3 = 0xB in one instruction -> N+1: reg strobe only, value 0xA. N+2: csr strobe only, wcsrno_WB = 3, value 0xB. in_ready = 0 at N+1.
- Write to x0 with value 0xFF -> no strobe; retired_count still increments.
- Counts 1, 2, 4 -> order_error rises after the third accept and stays high. Reset asserted -> order_error = 0 and retired_count = 0.
- CSR 0xF write -> strobe at N+1, halt = 1 and in_ready = 0 from N+2; further in_valid is ignored. Reset asserted while in CSR_PEND -> no CSR strobe.
